home_inventory_event_engine: RTL and testbench

//  Parametrised successor of the per-channel threshold event detector. Adds per-channel hysteresis

---
 rtl/home_inventory_event_engine_pkg.sv | 28 ++
 rtl/home_inventory_evt_fifo.sv | 95 +++++++++
 rtl/home_inventory_event_engine.sv | 205 ++++++++++++++++++++
 tb/tb_home_inventory_event_engine.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/home_inventory_event_engine_pkg.sv
// Shared definitions for the home inventory event engine.
//   - Default build parameters (channel count, widths, FIFO depth).
//   - Drop counter width and the event-record layout {mask, ts}.
//   - Per-channel trigger FSM state type.
package home_inventory_event_engine_pkg;

  localparam int DEF_NCH        = 8;
  localparam int DEF_SW         = 32;
  localparam int DEF_TSW        = 32;
  localparam int DEF_CW         = 32;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DROP_CNT_W     = 16;

  // Record layout: timestamp in the low bits, fired mask directly above it.
  localparam int REC_TS_LSB = 0;

  function automatic int rec_mask_lsb(input int tsw);
    return REC_TS_LSB + tsw;
  endfunction

  // ARMED: the next over-threshold sample fires.
  // FIRED: waiting for the sample to fall below the re-arm level.
  typedef enum logic {
    CH_ARMED = 1'b0,
    CH_FIRED = 1'b1
  } ch_state_e;

endpackage

// File: rtl/home_inventory_evt_fifo.sv
// Synchronous event-record FIFO with drop accounting.
// Handshake: a record is popped on any cycle where o_valid && i_ready.
//   o_data is stable while o_valid && !i_ready. A push into a full FIFO
//   without a simultaneous pop is dropped (the newest record is lost).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_push, i_data  write request and record
//   o_valid, i_ready, o_data   read side (head of FIFO, zero when empty)
//   o_level         number of entries held
//   o_overflow      sticky flag: a record was dropped
//   o_drop_count    saturating count of dropped records
//   i_ovf_clr       clears o_overflow/o_drop_count (a same-cycle drop wins)
module home_inventory_evt_fifo
  import home_inventory_event_engine_pkg::*;
#(
  parameter int W     = 40,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [W-1:0]            i_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [W-1:0]            o_data,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_overflow,
  output logic [DROP_CNT_W-1:0]   o_drop_count,
  input  logic                    i_ovf_clr
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]            r_mem [DEPTH];
  logic [AW:0]             r_wr_ptr;
  logic [AW:0]             r_rd_ptr;
  logic                    r_overflow;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;

  logic [AW:0]             w_level;
  logic                    w_full;
  logic                    w_valid;
  logic                    w_pop;
  logic                    w_wr;
  logic                    w_drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == (AW+1)'(DEPTH));
  assign w_valid = (w_level != '0);
  assign w_pop   = w_valid & i_ready;
  // When full, a pop in the same cycle frees the slot the push lands in.
  assign w_wr    = i_push & (~w_full | w_pop);
  assign w_drop  = i_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (i_ovf_clr) begin
          r_drop_cnt <= DROP_CNT_W'(1);
        end else if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + 1'b1;
        end
      end else if (i_ovf_clr) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end
    end
  end

  assign o_valid      = w_valid;
  assign o_data       = w_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
  assign o_level      = w_level;
  assign o_overflow   = r_overflow;
  assign o_drop_count = r_drop_cnt;

endmodule

// File: rtl/home_inventory_event_engine.sv
// Per-channel threshold event engine with hysteresis, edge/level mode,
// saturating event counters, per-channel timestamps and an event-record FIFO.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   sample_valid, ts_now        sample strobe and its timestamp
//   evt_en, edge_mode           per-channel enable and mode (1 = edge + hysteresis)
//   thresh_flat, hyst_flat      per-channel threshold / hysteresis, channel i at [i*SW +: SW]
//   sample_flat                 per-channel sample
//   clr_counts                  per-channel counter clear pulse
//   evt_count_flat              saturating event counters
//   last_delta_flat             delta between each channel's last two events
//   last_ts_ch_flat             timestamp of each channel's last event
//   last_ts                     timestamp of the most recent event on any channel
//   rd_valid/rd_ready           record read handshake (pop on rd_valid && rd_ready)
//   rd_mask, rd_ts              head record
//   fifo_level, fifo_overflow, drop_count, ovf_clr   FIFO status and clear
// Per-channel FSM state is available as g_ch[i].r_state.
module home_inventory_event_engine
  import home_inventory_event_engine_pkg::*;
#(
  parameter int NCH        = DEF_NCH,
  parameter int SW         = DEF_SW,
  parameter int TSW        = DEF_TSW,
  parameter int CW         = DEF_CW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_valid,
  input  logic [TSW-1:0]                 ts_now,
  input  logic [NCH-1:0]                 evt_en,
  input  logic [NCH-1:0]                 edge_mode,
  input  logic [NCH*SW-1:0]              thresh_flat,
  input  logic [NCH*SW-1:0]              hyst_flat,
  input  logic [NCH*SW-1:0]              sample_flat,
  input  logic [NCH-1:0]                 clr_counts,
  output logic [NCH*CW-1:0]              evt_count_flat,
  output logic [NCH*TSW-1:0]             last_delta_flat,
  output logic [NCH*TSW-1:0]             last_ts_ch_flat,
  output logic [TSW-1:0]                 last_ts,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [NCH-1:0]                 rd_mask,
  output logic [TSW-1:0]                 rd_ts,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           fifo_overflow,
  output logic [DROP_CNT_W-1:0]          drop_count,
  input  logic                           ovf_clr
);

  localparam int REC_W    = NCH + TSW;
  localparam int MASK_LSB = rec_mask_lsb(TSW);

  logic [NCH-1:0]   w_hit_mask;
  logic [TSW-1:0]   r_last_ts;
  logic [REC_W-1:0] w_push_rec;
  logic [REC_W-1:0] w_head_rec;
  logic             w_push;

  genvar gi;
  for (gi = 0; gi < NCH; gi++) begin : g_ch
    ch_state_e       r_state;
    ch_state_e       w_state_nxt;
    ch_state_e       w_state_eff;
    logic            r_en_d;
    logic            r_rise_pend;
    logic            r_seen;
    logic [CW-1:0]   r_count;
    logic [TSW-1:0]  r_last_ts_ch;
    logic [TSW-1:0]  r_last_delta;

    logic [SW-1:0]   w_sample;
    logic [SW-1:0]   w_thresh;
    logic [SW-1:0]   w_hyst;
    logic [SW-1:0]   w_rearm;
    logic            w_en;
    logic            w_rise;
    logic            w_over;
    logic            w_hit;
    logic            w_seen_eff;
    logic [TSW-1:0]  w_last_ts_eff;

    assign w_sample = sample_flat[gi*SW +: SW];
    assign w_thresh = thresh_flat[gi*SW +: SW];
    assign w_hyst   = hyst_flat[gi*SW +: SW];
    assign w_en     = evt_en[gi];
    assign w_over   = (w_sample >= w_thresh);
    // Re-arm level saturates at zero; a zero level can never be undershot.
    assign w_rearm  = (w_thresh > w_hyst) ? (w_thresh - w_hyst) : '0;

    // A rise is live from the cycle the enable goes high until the first
    // enabled sample consumes it; dropping the enable discards it.
    assign w_rise        = w_en & (r_rise_pend | ~r_en_d);
    // History as seen by this sample once a pending rise has wiped it.
    assign w_seen_eff    = r_seen & ~w_rise;
    assign w_last_ts_eff = w_rise ? '0 : r_last_ts_ch;

    always_comb begin
      w_state_eff = r_state;
      w_state_nxt = r_state;
      w_hit       = 1'b0;
      if (!w_en || !edge_mode[gi]) begin
        w_state_nxt = CH_ARMED;
      end
      if (w_en && sample_valid) begin
        if (w_rise) begin
          w_state_eff = CH_ARMED;
        end
        if (!edge_mode[gi]) begin
          w_hit = w_over;
        end else begin
          case (w_state_eff)
            CH_ARMED: begin
              w_hit       = w_over;
              w_state_nxt = w_over ? CH_FIRED : CH_ARMED;
            end
            CH_FIRED: begin
              w_state_nxt = (w_sample < w_rearm) ? CH_ARMED : CH_FIRED;
            end
            default: w_state_nxt = CH_ARMED;
          endcase
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state      <= CH_ARMED;
        r_en_d       <= 1'b0;
        r_rise_pend  <= 1'b0;
        r_seen       <= 1'b0;
        r_count      <= '0;
        r_last_ts_ch <= '0;
        r_last_delta <= '0;
      end else begin
        r_state     <= w_state_nxt;
        r_en_d      <= w_en;
        r_rise_pend <= w_rise & ~sample_valid;

        if (sample_valid && w_rise) begin
          r_seen       <= 1'b0;
          r_last_ts_ch <= '0;
          r_last_delta <= '0;
        end
        if (w_hit) begin
          r_last_delta <= w_seen_eff ? (ts_now - w_last_ts_eff) : '0;
          r_last_ts_ch <= ts_now;
          r_seen       <= 1'b1;
        end

        // Clear then increment when both land on the same cycle.
        if (clr_counts[gi]) begin
          r_count <= w_hit ? CW'(1) : '0;
        end else if (w_hit && (r_count != '1)) begin
          r_count <= r_count + CW'(1);
        end
      end
    end

    assign w_hit_mask[gi]                 = w_hit;
    assign evt_count_flat[gi*CW +: CW]    = r_count;
    assign last_delta_flat[gi*TSW +: TSW] = r_last_delta;
    assign last_ts_ch_flat[gi*TSW +: TSW] = r_last_ts_ch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_ts <= '0;
    end else if (|w_hit_mask) begin
      r_last_ts <= ts_now;
    end
  end

  assign last_ts = r_last_ts;

  // One record per sample carrying every channel that fired on it.
  assign w_push = sample_valid & (|w_hit_mask);

  always_comb begin
    w_push_rec                         = '0;
    w_push_rec[MASK_LSB +: NCH]        = w_hit_mask;
    w_push_rec[REC_TS_LSB +: TSW]      = ts_now;
  end

  home_inventory_evt_fifo #(
    .W     (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_data       (w_push_rec),
    .o_valid      (rd_valid),
    .i_ready      (rd_ready),
    .o_data       (w_head_rec),
    .o_level      (fifo_level),
    .o_overflow   (fifo_overflow),
    .o_drop_count (drop_count),
    .i_ovf_clr    (ovf_clr)
  );

  assign rd_mask = w_head_rec[MASK_LSB +: NCH];
  assign rd_ts   = w_head_rec[REC_TS_LSB +: TSW];

endmodule

// File: tb/tb_home_inventory_event_engine.sv
module tb_home_inventory_event_engine;

  localparam int NCH   = 8;
  localparam int SW    = 32;
  localparam int TSW   = 32;
  localparam int CW    = 4;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                clk;
  logic                rst;
  logic                sample_valid;
  logic [TSW-1:0]      ts_now;
  logic [NCH-1:0]      evt_en;
  logic [NCH-1:0]      edge_mode;
  logic [NCH*SW-1:0]   thresh_flat;
  logic [NCH*SW-1:0]   hyst_flat;
  logic [NCH*SW-1:0]   sample_flat;
  logic [NCH-1:0]      clr_counts;
  logic [NCH*CW-1:0]   evt_count_flat;
  logic [NCH*TSW-1:0]  last_delta_flat;
  logic [NCH*TSW-1:0]  last_ts_ch_flat;
  logic [TSW-1:0]      last_ts;
  logic                rd_valid;
  logic                rd_ready;
  logic [NCH-1:0]      rd_mask;
  logic [TSW-1:0]      rd_ts;
  logic [LW-1:0]       fifo_level;
  logic                fifo_overflow;
  logic [15:0]         drop_count;
  logic                ovf_clr;

  logic [SW-1:0] t_thresh [NCH];
  logic [SW-1:0] t_hyst   [NCH];
  logic [SW-1:0] t_smp    [NCH];

  int checks;
  int failures;

  home_inventory_event_engine #(
    .NCH(NCH), .SW(SW), .TSW(TSW), .CW(CW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sample_valid    (sample_valid),
    .ts_now          (ts_now),
    .evt_en          (evt_en),
    .edge_mode       (edge_mode),
    .thresh_flat     (thresh_flat),
    .hyst_flat       (hyst_flat),
    .sample_flat     (sample_flat),
    .clr_counts      (clr_counts),
    .evt_count_flat  (evt_count_flat),
    .last_delta_flat (last_delta_flat),
    .last_ts_ch_flat (last_ts_ch_flat),
    .last_ts         (last_ts),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .rd_mask         (rd_mask),
    .rd_ts           (rd_ts),
    .fifo_level      (fifo_level),
    .fifo_overflow   (fifo_overflow),
    .drop_count      (drop_count),
    .ovf_clr         (ovf_clr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    thresh_flat = '0;
    hyst_flat   = '0;
    sample_flat = '0;
    for (int i = 0; i < NCH; i++) begin
      thresh_flat[i*SW +: SW] = t_thresh[i];
      hyst_flat[i*SW +: SW]   = t_hyst[i];
      sample_flat[i*SW +: SW] = t_smp[i];
    end
  end

  function automatic logic [CW-1:0] cnt(input int ch);
    return evt_count_flat[ch*CW +: CW];
  endfunction
  function automatic logic [TSW-1:0] dlt(input int ch);
    return last_delta_flat[ch*TSW +: TSW];
  endfunction
  function automatic logic [TSW-1:0] lts(input int ch);
    return last_ts_ch_flat[ch*TSW +: TSW];
  endfunction

  // Driver tasks: all run from negedge to negedge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    ts_now = '0;
    evt_en = '0;
    edge_mode = '0;
    clr_counts = '0;
    rd_ready = 1'b0;
    ovf_clr = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      t_thresh[i] = 32'd100;
      t_hyst[i]   = 32'd0;
      t_smp[i]    = 32'd0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sample_cycle(input logic [TSW-1:0] ts);
    sample_valid = 1'b1;
    ts_now = ts;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (evt_count_flat !== '0) begin failures++; $display("FAIL reset_counts got=%0h exp=0", evt_count_flat); end
    checks++; if (last_ts !== '0) begin failures++; $display("FAIL reset_last_ts got=%0h exp=0", last_ts); end
    checks++; if (last_delta_flat !== '0) begin failures++; $display("FAIL reset_delta got=%0h exp=0", last_delta_flat); end
    checks++; if (rd_valid !== 1'b0 || fifo_level !== '0) begin failures++; $display("FAIL reset_fifo valid=%0b level=%0d exp 0/0", rd_valid, fifo_level); end
    checks++; if (fifo_overflow !== 1'b0 || drop_count !== '0) begin failures++; $display("FAIL reset_ovf ovf=%0b drops=%0d exp 0/0", fifo_overflow, drop_count); end
    checks++; if (rd_mask !== '0 || rd_ts !== '0) begin failures++; $display("FAIL reset_rd mask=%0h ts=%0h exp 0/0", rd_mask, rd_ts); end
  endtask

  task automatic test_level();
    do_reset();
    evt_en[0] = 1'b1;
    t_smp[0] = 32'd150;
    sample_cycle(32'd10);
    checks++; if (rd_valid !== 1'b1 || rd_ts !== 32'd10) begin failures++; $display("FAIL level_first_rec valid=%0b ts=%0d exp 1/10", rd_valid, rd_ts); end
    sample_cycle(32'd25);
    checks++; if (cnt(0) !== 4'd2) begin failures++; $display("FAIL level_count got=%0d exp=2", cnt(0)); end
    checks++; if (dlt(0) !== 32'd15) begin failures++; $display("FAIL level_delta got=%0d exp=15", dlt(0)); end
    checks++; if (last_ts !== 32'd25 || lts(0) !== 32'd25) begin failures++; $display("FAIL level_ts last=%0d ch=%0d exp 25/25", last_ts, lts(0)); end
    checks++; if (fifo_level !== LW'(2) || rd_mask !== 8'h01 || rd_ts !== 32'd10) begin failures++; $display("FAIL level_head level=%0d mask=%0h ts=%0d exp 2/01/10", fifo_level, rd_mask, rd_ts); end
    pop_one();
    checks++; if (rd_mask !== 8'h01 || rd_ts !== 32'd25 || fifo_level !== LW'(1)) begin failures++; $display("FAIL level_second mask=%0h ts=%0d level=%0d exp 01/25/1", rd_mask, rd_ts, fifo_level); end
    pop_one();
    checks++; if (rd_valid !== 1'b0 || fifo_level !== '0) begin failures++; $display("FAIL level_drain valid=%0b level=%0d exp 0/0", rd_valid, fifo_level); end
  endtask

  task automatic test_edge();
    logic [SW-1:0] seq_a [4];
    logic [SW-1:0] seq_b [4];
    seq_a[0] = 150; seq_a[1] = 150; seq_a[2] = 90; seq_a[3] = 150;
    seq_b[0] = 150; seq_b[1] = 150; seq_b[2] = 70; seq_b[3] = 150;
    // 90 stays at or above the re-arm level of 80: only the first sample fires.
    do_reset();
    evt_en[1] = 1'b1; edge_mode[1] = 1'b1; t_hyst[1] = 32'd20;
    for (int k = 0; k < 4; k++) begin
      t_smp[1] = seq_a[k];
      sample_cycle(TSW'(k + 1));
    end
    checks++; if (cnt(1) !== 4'd1) begin failures++; $display("FAIL edge_no_rearm_count got=%0d exp=1", cnt(1)); end
    checks++; if (lts(1) !== 32'd1 || fifo_level !== LW'(1)) begin failures++; $display("FAIL edge_no_rearm_ts ts=%0d level=%0d exp 1/1", lts(1), fifo_level); end
    // 70 drops below 80: re-arms, fires again at ts4.
    do_reset();
    evt_en[1] = 1'b1; edge_mode[1] = 1'b1; t_hyst[1] = 32'd20;
    for (int k = 0; k < 4; k++) begin
      t_smp[1] = seq_b[k];
      sample_cycle(TSW'(k + 1));
    end
    checks++; if (cnt(1) !== 4'd2) begin failures++; $display("FAIL edge_rearm_count got=%0d exp=2", cnt(1)); end
    checks++; if (dlt(1) !== 32'd3 || lts(1) !== 32'd4) begin failures++; $display("FAIL edge_rearm_delta delta=%0d ts=%0d exp 3/4", dlt(1), lts(1)); end
    checks++; if (fifo_level !== LW'(2) || rd_mask !== 8'h02 || rd_ts !== 32'd1) begin failures++; $display("FAIL edge_rearm_fifo level=%0d mask=%0h ts=%0d exp 2/02/1", fifo_level, rd_mask, rd_ts); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    evt_en = 8'h25;   // ch0 enabled but below threshold
    t_smp[2] = 32'd150;
    t_smp[5] = 32'd100;  // exactly at threshold counts as over
    sample_cycle(32'd40);
    checks++; if (fifo_level !== LW'(1) || rd_mask !== 8'h24 || rd_ts !== 32'd40) begin failures++; $display("FAIL simul_rec level=%0d mask=%0h ts=%0d exp 1/24/40", fifo_level, rd_mask, rd_ts); end
    checks++; if (lts(2) !== 32'd40 || lts(5) !== 32'd40) begin failures++; $display("FAIL simul_ts ch2=%0d ch5=%0d exp 40/40", lts(2), lts(5)); end
    checks++; if (cnt(0) !== 4'd0 || cnt(2) !== 4'd1 || cnt(5) !== 4'd1) begin failures++; $display("FAIL simul_counts c0=%0d c2=%0d c5=%0d exp 0/1/1", cnt(0), cnt(2), cnt(5)); end
  endtask

  task automatic test_enable_toggle();
    do_reset();
    evt_en[3] = 1'b1; edge_mode[3] = 1'b1;
    t_smp[3] = 32'd150;
    sample_cycle(32'd5);
    sample_cycle(32'd20);  // still FIRED, re-arm level 100 not undershot
    checks++; if (cnt(3) !== 4'd1 || lts(3) !== 32'd5) begin failures++; $display("FAIL en_first count=%0d ts=%0d exp 1/5", cnt(3), lts(3)); end
    evt_en[3] = 1'b0;
    @(negedge clk);
    evt_en[3] = 1'b1;
    sample_cycle(32'd50);
    checks++; if (cnt(3) !== 4'd2) begin failures++; $display("FAIL en_rise_count got=%0d exp=2", cnt(3)); end
    checks++; if (dlt(3) !== 32'd0 || lts(3) !== 32'd50) begin failures++; $display("FAIL en_rise_hist delta=%0d ts=%0d exp 0/50", dlt(3), lts(3)); end
    sample_cycle(32'd60);
    checks++; if (cnt(3) !== 4'd2) begin failures++; $display("FAIL en_refired_count got=%0d exp=2", cnt(3)); end
    // Rise that is withdrawn before any sample, then a disabled sample.
    evt_en[3] = 1'b0;
    @(negedge clk);
    evt_en[3] = 1'b1;
    @(negedge clk);
    evt_en[3] = 1'b0;
    sample_cycle(32'd70);
    checks++; if (cnt(3) !== 4'd2 || lts(3) !== 32'd50 || fifo_level !== LW'(2)) begin failures++; $display("FAIL en_disabled count=%0d ts=%0d level=%0d exp 2/50/2", cnt(3), lts(3), fifo_level); end
  endtask

  task automatic test_overflow();
    logic [TSW-1:0] exp_ts;
    do_reset();
    evt_en[0] = 1'b1;
    t_smp[0] = 32'd150;
    for (int k = 0; k < DEPTH + 3; k++) begin
      sample_cycle(TSW'(k + 1));
    end
    checks++; if (fifo_level !== LW'(16)) begin failures++; $display("FAIL ovf_level got=%0d exp=16", fifo_level); end
    checks++; if (fifo_overflow !== 1'b1 || drop_count !== 16'd3) begin failures++; $display("FAIL ovf_drops ovf=%0b drops=%0d exp 1/3", fifo_overflow, drop_count); end
    checks++; if (rd_ts !== 32'd1) begin failures++; $display("FAIL ovf_head got=%0d exp=1", rd_ts); end
    // Full with simultaneous push and pop: nothing lost.
    rd_ready = 1'b1;
    sample_cycle(32'd100);
    rd_ready = 1'b0;
    checks++; if (fifo_level !== LW'(16) || drop_count !== 16'd3 || rd_ts !== 32'd2) begin failures++; $display("FAIL ovf_pushpop level=%0d drops=%0d head=%0d exp 16/3/2", fifo_level, drop_count, rd_ts); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++; if (fifo_overflow !== 1'b0 || drop_count !== 16'd0) begin failures++; $display("FAIL ovf_clear ovf=%0b drops=%0d exp 0/0", fifo_overflow, drop_count); end
    // Clear coinciding with a drop: the drop wins.
    ovf_clr = 1'b1;
    sample_cycle(32'd200);
    ovf_clr = 1'b0;
    checks++; if (fifo_overflow !== 1'b1 || drop_count !== 16'd1) begin failures++; $display("FAIL ovf_clr_vs_drop ovf=%0b drops=%0d exp 1/1", fifo_overflow, drop_count); end
    for (int k = 0; k < DEPTH; k++) begin
      exp_ts = (k == DEPTH - 1) ? 32'd100 : TSW'(k + 2);
      checks++; if (rd_valid !== 1'b1 || rd_ts !== exp_ts) begin failures++; $display("FAIL ovf_drain_%0d valid=%0b ts=%0d exp 1/%0d", k, rd_valid, rd_ts, exp_ts); end
      pop_one();
    end
    checks++; if (rd_valid !== 1'b0 || fifo_level !== '0) begin failures++; $display("FAIL ovf_empty valid=%0b level=%0d exp 0/0", rd_valid, fifo_level); end
  endtask

  task automatic test_saturation_wrap();
    do_reset();
    evt_en[0] = 1'b1;
    t_smp[0] = 32'd150;
    rd_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      sample_cycle(TSW'(k + 1));
    end
    checks++; if (cnt(0) !== 4'd15) begin failures++; $display("FAIL sat_reach got=%0d exp=15", cnt(0)); end
    sample_cycle(32'd16);
    sample_cycle(32'd17);
    rd_ready = 1'b0;
    checks++; if (cnt(0) !== 4'd15 || dlt(0) !== 32'd1) begin failures++; $display("FAIL sat_hold count=%0d delta=%0d exp 15/1", cnt(0), dlt(0)); end
    clr_counts[0] = 1'b1;
    @(negedge clk);
    clr_counts[0] = 1'b0;
    checks++; if (cnt(0) !== 4'd0 || dlt(0) !== 32'd1 || lts(0) !== 32'd17) begin failures++; $display("FAIL clr_only count=%0d delta=%0d ts=%0d exp 0/1/17", cnt(0), dlt(0), lts(0)); end
    sample_cycle(32'd20);
    sample_cycle(32'd21);
    clr_counts[0] = 1'b1;
    sample_cycle(32'd22);
    clr_counts[0] = 1'b0;
    checks++; if (cnt(0) !== 4'd1) begin failures++; $display("FAIL clr_with_hit got=%0d exp=1", cnt(0)); end
    // Timestamp wrap on channel 1.
    do_reset();
    evt_en[1] = 1'b1;
    t_smp[1] = 32'd500;
    sample_cycle(32'hFFFF_FFF0);
    sample_cycle(32'h0000_0010);
    checks++; if (dlt(1) !== 32'h20 || last_ts !== 32'h10) begin failures++; $display("FAIL ts_wrap delta=%0h last=%0h exp 20/10", dlt(1), last_ts); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    test_reset();
    test_level();
    test_edge();
    test_simultaneous();
    test_enable_toggle();
    test_overflow();
    test_saturation_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
